johnson_phase_decoder: RTL and testbench
========================================

// Module: johnson_phase_decoder
// PURPOSE
//  Downstream consumer of the Johnson counter. Samples the WIDTH-bit Johnson code every clock.
//  Decodes it into a one-hot phase bus and a binary phase index. Counts full periods.
//  Supervises the sequence: flags illegal codes and illegal steps, and reports lock status.
//  Drives phase-timed logic such as stepper or multiphase strobes.
// PARAMETERS
//  WIDTH     4   Johnson register width; 2*WIDTH states per period.
//  LOCK_CNT  4   consecutive legal advances needed to go ACQUIRE->LOCKED (1..15).
//  PCNT_W    8   width of the period counter.
// PORTS
//  clk        in   1              rising-edge clock, shared with the Johnson counter
//  reset      in   1              synchronous, active-low reset (0 = reset)
//  jc_in      in   WIDTH          Johnson code from the counter's out
//  phase      out  2*WIDTH        registered one-hot phase; bit k set while in state k
//  phase_idx  out  $clog2(2*WIDTH) registered binary state index 0..2W-1
//  wrap       out  1              one-cycle pulse when the index steps 2W-1 -> 0
//  period_cnt out  PCNT_W         count of wraps; wraps modulo 2^PCNT_W
//  locked     out  1              FSM is in LOCKED
//  err        out  1              sticky error; cleared only by reset
// BEHAVIOUR
//  Code convention
//   - The counter shifts as out <= {out[W-2:0], ~out[W-1]}.
//   - Sequence for W=4: 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000.
//   - Legal code: ones contiguous from the LSB (idx = popcount), or zeros contiguous
//     from the LSB with the MSB set (idx = 2W - popcount).
//   - There are 2W legal codes. Every other code is illegal.
//  Pipeline
//   - jc_in is registered once (cur). The previously registered code is kept as prev.
//   - Decode is combinational on cur; results are registered.
//   - phase, phase_idx, wrap and err therefore follow jc_in with 2 clocks latency.
//  Step rule, comparing idx(cur) with idx(prev)
//   - equal  = HOLD (legal, no advance)
//   - (prev+1) mod 2W = ADVANCE
//   - anything else = BAD_STEP
//   - An illegal code = BAD_CODE.
//   - On the first valid sample after reset, prev is invalid, so no step check is made.
//  Outputs on a BAD_CODE sample
//   - phase and phase_idx hold their last legal value.
//   - err is set.
//   - wrap stays low.
//  wrap and period_cnt
//   - wrap = ADVANCE && prev idx == 2W-1.
//   - period_cnt increments in the same cycle wrap is asserted.
//  FSM (states in the package)
//   - ACQUIRE: run count adv_run increments on each ADVANCE and stays put on HOLD.
//     On reaching LOCK_CNT, go to LOCKED.
//   - ACQUIRE: BAD_CODE or BAD_STEP sets adv_run to 0 and the FSM stays in ACQUIRE.
//   - LOCKED: HOLD and ADVANCE keep LOCKED.
//     BAD_CODE or BAD_STEP go to FAULT and set err.
//   - FAULT: locked=0. Returns to ACQUIRE (adv_run=0) on the first legal code.
//     err stays set.
//  Reset (reset==0 at a rising edge), with priority over everything
//   - phase = 1 (state 0), phase_idx = 0, wrap = 0, period_cnt = 0.
//   - locked = 0, err = 0, FSM = ACQUIRE, adv_run = 0, prev marked invalid.
//   - Reset asserted mid-period behaves identically; no partial state survives.
//  Boundary cases
//   - A counter stalled by its own reset (0000 held) is HOLD at idx 0: legal, no wrap.
//   - period_cnt overflow wraps silently to 0.
// STRUCTURE
//  - Package johnson_pkg: FSM state enum (ACQUIRE, LOCKED, FAULT); step-class enum
//    (HOLD, ADVANCE, BAD_STEP, BAD_CODE); function jc_states(W) = 2*W.
//  - Sub-module johnson_code_check: combinational W-bit legality check plus idx decode.
//    Reused by future Johnson-side blocks.
//  - Top: input and prev registers, step classifier, FSM, period counter, output registers.
// TESTING (WIDTH=4, LOCK_CNT=4)
//  - Reset held 3 clocks -> phase=00000001, idx=0, err=0, locked=0, period_cnt=0.
//  - Counter free-running 2 periods -> idx 0..7 repeating; wrap pulses once per 8 clocks;
//    locked=1 four clocks after the first advance; period_cnt=2.
//  - Force jc_in=0101 for 1 clock while LOCKED -> err=1, locked=0, phase frozen;
//    legal codes resume -> relocks after 4 advances; err remains 1.
//  - Skip step 0011->1111 -> BAD_STEP; err=1, FSM goes to FAULT.
//  - Assert reset mid-period at idx 5 -> next cycle idx=0 and all outputs at reset values;
//    err cleared.
//  - Preload/run 256 periods, PCNT_W=8 -> period_cnt wraps 255->0 with wrap=1, no err.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-counter consumers.
//   fsm_state_e  : lock supervisor states (ACQUIRE, LOCKED, FAULT)
//   step_class_e : classification of one sample against the previous one
//   jc_states()  : number of distinct states of a W-bit Johnson counter
package johnson_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    FAULT   = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    ADVANCE  = 2'd1,
    BAD_STEP = 2'd2,
    BAD_CODE = 2'd3
  } step_class_e;

  function automatic int jc_states(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Bus between a Johnson counter (master side) and the phase decoder (slave side).
//   jc_in      : Johnson code from the counter
//   phase      : one-hot phase, 2*WIDTH bits
//   phase_idx  : binary phase index
//   wrap       : one-cycle pulse on the 2W-1 -> 0 step
//   period_cnt : number of completed periods (modulo 2^PCNT_W)
//   locked     : supervisor is in LOCKED
//   err        : sticky sequence error
interface johnson_phase_decoder_if
  import johnson_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
);
  localparam int STATES = jc_states(WIDTH);
  localparam int IDX_W  = $clog2(STATES);

  logic [WIDTH-1:0]  jc_in;
  logic [STATES-1:0] phase;
  logic [IDX_W-1:0]  phase_idx;
  logic              wrap;
  logic [PCNT_W-1:0] period_cnt;
  logic              locked;
  logic              err;

  modport master (
    output jc_in,
    input  phase, phase_idx, wrap, period_cnt, locked, err
  );

  modport slave (
    input  jc_in,
    output phase, phase_idx, wrap, period_cnt, locked, err
  );

endinterface

// File: rtl/johnson_code_check.sv
// Combinational legality check and index decode for a WIDTH-bit Johnson code.
//   code  : Johnson code to inspect
//   legal : 1 when code is one of the 2*WIDTH reachable states
//   idx   : state index 0..2*WIDTH-1 (0 when illegal)
// Legal codes are either a run of ones from the LSB (first half period, idx =
// popcount) or a run of zeros from the LSB with the MSB set (second half,
// idx = 2W - popcount). All-ones matches the first form and decodes to W.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int  WIDTH = 4,
  localparam int IDX_W = $clog2(jc_states(WIDTH))
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ones;
  logic [WIDTH-1:0] code_inv;
  logic             lo_run;
  logic             hi_run;

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + IDX_W'(code[i]);
    end
  end

  assign code_inv = ~code;

  // x & (x+1) clears the lowest run of ones; zero result means the ones
  // (if any) were one contiguous run starting at the LSB.
  assign lo_run = ((code & (code + WIDTH'(1))) == '0);
  assign hi_run = code[WIDTH-1] && ((code_inv & (code_inv + WIDTH'(1))) == '0);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    legal = 1'b0;
    idx   = '0;
    if (lo_run) begin
      legal = 1'b1;
      idx   = ones;
    end else if (hi_run) begin
      legal = 1'b1;
      idx   = IDX_W'(jc_states(WIDTH) - int'(ones));
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder and sequence supervisor.
//   clk   : rising-edge clock shared with the counter
//   reset : synchronous active-low reset
//   bus   : slave side of johnson_phase_decoder_if (jc_in in; phase,
//           phase_idx, wrap, period_cnt, locked, err out)
// jc_in is registered (cur); the sample before it is kept as prev. The step
// between them is classified and the outputs are registered, giving two
// clocks of latency from jc_in to phase/phase_idx/wrap/err.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int PCNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  johnson_phase_decoder_if.slave bus
);

  localparam int STATES = jc_states(WIDTH);
  localparam int IDX_W  = $clog2(STATES);
  localparam int RUN_W  = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STATES - 1);

  // Input stage
  logic [WIDTH-1:0]  cur_q;
  logic              cur_vld_q;
  logic [IDX_W-1:0]  prev_idx_q;
  logic              prev_vld_q;

  // Decode / classification
  logic              cur_legal;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  adv_idx;
  step_class_e       step;

  // Supervisor
  fsm_state_e        state_q, state_d;
  logic [RUN_W-1:0]  adv_run_q, adv_run_d;
  logic              locked_o;
  logic              err_set;
  logic              wrap_set;

  // Output registers
  logic [STATES-1:0] phase_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wrap_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              err_q;

  johnson_code_check #(.WIDTH(WIDTH)) u_code_check (
    .code  (cur_q),
    .legal (cur_legal),
    .idx   (cur_idx)
  );

  assign adv_idx = (prev_idx_q == LAST_IDX) ? '0 : prev_idx_q + IDX_W'(1);

  // With no valid prev (first sample after reset or after an illegal code)
  // a legal code is treated as HOLD: accepted, but it cannot advance.
  always_comb begin
    step = HOLD;
    if (!cur_legal) begin
      step = BAD_CODE;
    end else if (prev_vld_q && (cur_idx != prev_idx_q)) begin
      step = (cur_idx == adv_idx) ? ADVANCE : BAD_STEP;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled at the clock edge only, and all sequential
    // state uses non-blocking assignments so every register sees pre-edge
    // values regardless of block ordering.
    if (!reset) begin
      state_q   <= ACQUIRE;
      adv_run_q <= '0;
    end else begin
      state_q   <= state_d;
      adv_run_q <= adv_run_d;
    end
  end

  // FSM: next state; nothing moves until cur holds a real sample.
  always_comb begin
    state_d   = state_q;
    adv_run_d = adv_run_q;
    if (cur_vld_q) begin
      unique case (state_q)
        ACQUIRE: begin
          if (step == ADVANCE) begin
            adv_run_d = adv_run_q + RUN_W'(1);
            if (adv_run_d == RUN_W'(LOCK_CNT)) state_d = LOCKED;
          end else if (step == BAD_CODE || step == BAD_STEP) begin
            adv_run_d = '0;
          end
        end
        LOCKED: begin
          if (step == BAD_CODE || step == BAD_STEP) begin
            state_d   = FAULT;
            adv_run_d = '0;
          end
        end
        FAULT: begin
          if (step != BAD_CODE) begin
            state_d   = ACQUIRE;
            adv_run_d = '0;
          end
        end
        default: begin
          state_d   = ACQUIRE;
          adv_run_d = '0;
        end
      endcase
    end
  end

  // FSM: outputs. An illegal code is always an error; a bad step only
  // counts as one once the sequence has been locked.
  always_comb begin
    locked_o = (state_q == LOCKED);
    err_set  = cur_vld_q &&
               ((step == BAD_CODE) || ((state_q == LOCKED) && (step == BAD_STEP)));
    wrap_set = cur_vld_q && (step == ADVANCE) && (prev_idx_q == LAST_IDX);
  end

  // Input, prev and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q      <= '0;
      cur_vld_q  <= 1'b0;
      prev_idx_q <= '0;
      prev_vld_q <= 1'b0;
      phase_q    <= STATES'(1);
      idx_q      <= '0;
      wrap_q     <= 1'b0;
      pcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      cur_q      <= bus.jc_in;
      cur_vld_q  <= 1'b1;
      prev_idx_q <= cur_idx;
      prev_vld_q <= cur_vld_q && cur_legal;
      wrap_q     <= wrap_set;
      if (wrap_set) pcnt_q <= pcnt_q + PCNT_W'(1);
      // Illegal codes leave the phase outputs on the last legal state.
      if (cur_vld_q && cur_legal) begin
        idx_q   <= cur_idx;
        phase_q <= STATES'(1) << cur_idx;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.phase_idx  = idx_q;
  assign bus.wrap       = wrap_q;
  assign bus.period_cnt = pcnt_q;
  assign bus.locked     = locked_o;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder (WIDTH=4, LOCK_CNT=4, PCNT_W=8).
// The reference model knows the legal codes only as the states visited by a
// Johnson counter stepping from 0000, and applies the step rules with plain
// modular index arithmetic.
module tb_johnson_phase_decoder;
  import johnson_pkg::*;

  localparam int W    = 4;
  localparam int N    = 2 * W;
  localparam int LOCK = 4;
  localparam int PW   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  johnson_phase_decoder_if #(.WIDTH(W), .PCNT_W(PW)) bus ();

  johnson_phase_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .PCNT_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Code tables built by running the counter rule
  logic [W-1:0] code_of [N];
  int           idx_of  [16];
  logic [W-1:0] gen;
  int           pos;

  // Reference model state
  logic [W-1:0] m_cur;
  bit           m_cur_vld;
  int           m_prev_idx;
  bit           m_prev_vld;
  int           m_idx;
  bit           m_wrap;
  int           m_pcnt;
  int           m_fsm;   // 0 acquiring, 1 locked, 2 faulted
  int           m_run;
  bit           m_err;

  function automatic void model_update(input logic [W-1:0] code, input logic rst_n);
    int ci;
    bit adv;
    bit bad;
    if (!rst_n) begin
      m_cur_vld = 0; m_prev_vld = 0; m_idx = 0; m_wrap = 0;
      m_pcnt = 0; m_fsm = 0; m_run = 0; m_err = 0;
      return;
    end
    m_wrap = 0;
    if (m_cur_vld) begin
      ci  = idx_of[m_cur];
      adv = 0;
      bad = 0;
      if (ci < 0) begin
        bad   = 1;
        m_err = 1;
      end else begin
        m_idx = ci;
        if (m_prev_vld && ci != m_prev_idx) begin
          if (ci == (m_prev_idx + 1) % N) adv = 1;
          else                            bad = 1;
        end
      end
      if (adv && m_prev_idx == N - 1) begin
        m_wrap = 1;
        m_pcnt = (m_pcnt + 1) % (1 << PW);
      end
      case (m_fsm)
        0: begin
          if (bad) m_run = 0;
          else if (adv) begin
            m_run++;
            if (m_run == LOCK) m_fsm = 1;
          end
        end
        1: if (bad) begin m_fsm = 2; m_err = 1; m_run = 0; end
        default: if (ci >= 0) begin m_fsm = 0; m_run = 0; end
      endcase
      m_prev_vld = (ci >= 0);
      m_prev_idx = ci;
    end else begin
      m_prev_vld = 0;
    end
    m_cur     = code;
    m_cur_vld = 1;
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus.phase, bus.phase_idx, bus.wrap, bus.period_cnt, bus.locked, bus.err};
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [7:0] ph;
    ph = 8'(1) << m_idx;
    return {ph, 3'(m_idx), m_wrap, 8'(m_pcnt), (m_fsm == 1), m_err};
  endfunction

  // One clock: drive on negedge, update model at posedge, settle for sampling.
  task automatic step(input logic [W-1:0] code, input logic rst_n);
    @(negedge clk);
    bus.jc_in = code;
    reset     = rst_n;
    @(posedge clk);
    model_update(code, rst_n);
    #1;
  endtask

  task automatic drive_next();
    step(code_of[pos % N], 1'b1);
    pos++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step('0, 1'b0);
    if (bus.phase !== 8'h01) begin failures++; $display("FAIL reset_phase got=%h exp=01", bus.phase); end
    checks++;
    if (bus.phase_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.phase_idx); end
    checks++;
    if ({bus.err, bus.locked, bus.wrap} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.err, bus.locked, bus.wrap});
    end
    checks++;
    if (bus.period_cnt !== 8'd0) begin failures++; $display("FAIL reset_pcnt got=%0d exp=0", bus.period_cnt); end
    checks++;
  endtask

  task automatic test_free_run();
    int wraps = 0;
    pos = 0;
    for (int k = 0; k < 18; k++) begin
      drive_next();
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL free_run k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      checks++;
      if (bus.wrap === 1'b1) wraps++;
      if (k == 4) begin
        if (bus.locked !== 1'b0) begin failures++; $display("FAIL free_run_prelock got=%b exp=0", bus.locked); end
        checks++;
      end
      if (k == 5) begin
        if (bus.locked !== 1'b1) begin failures++; $display("FAIL free_run_lock got=%b exp=1", bus.locked); end
        checks++;
      end
    end
    if (wraps != 2) begin failures++; $display("FAIL free_run_wraps got=%0d exp=2", wraps); end
    checks++;
    if (bus.period_cnt !== 8'd2) begin failures++; $display("FAIL free_run_pcnt got=%0d exp=2", bus.period_cnt); end
    checks++;
  endtask

  task automatic test_bad_code();
    logic [7:0] frozen;
    step(4'b0101, 1'b1);
    pos++;
    frozen = bus.phase;
    drive_next();
    if (bus.err !== 1'b1 || bus.locked !== 1'b0) begin
      failures++; $display("FAIL bad_code_flags got err=%b locked=%b exp err=1 locked=0", bus.err, bus.locked);
    end
    checks++;
    if (bus.phase !== frozen) begin failures++; $display("FAIL bad_code_frozen got=%h exp=%h", bus.phase, frozen); end
    checks++;
    for (int k = 0; k < 5; k++) begin
      drive_next();
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL bad_code_recover k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      checks++;
      if (k == 3) begin
        if (bus.locked !== 1'b0) begin failures++; $display("FAIL bad_code_early_lock got=%b exp=0", bus.locked); end
        checks++;
      end
    end
    if (bus.locked !== 1'b1 || bus.err !== 1'b1) begin
      failures++; $display("FAIL bad_code_relock got locked=%b err=%b exp locked=1 err=1", bus.locked, bus.err);
    end
    checks++;
  endtask

  task automatic test_bad_step();
    bit found = 0;
    step('0, 1'b0);
    pos = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_fsm == 1 && (pos % N) == 3) found = 1;
      else drive_next();
    end
    if (!found) begin failures++; $display("FAIL bad_step_setup got=timeout exp=locked at 0011"); end
    checks++;
    step(code_of[4], 1'b1);   // 0011 -> 1111 skips 0111
    pos = 5;
    drive_next();
    if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.phase_idx !== 3'd4) begin
      failures++;
      $display("FAIL bad_step_flags got err=%b locked=%b idx=%0d exp err=1 locked=0 idx=4",
               bus.err, bus.locked, bus.phase_idx);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      drive_next();
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL bad_step_after k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      drive_next();
      if (m_idx == 5) found = 1;
    end
    if (!found || bus.phase_idx !== 3'd5 || bus.err !== 1'b1) begin
      failures++; $display("FAIL reset_mid_setup got idx=%0d err=%b exp idx=5 err=1", bus.phase_idx, bus.err);
    end
    checks++;
    step(code_of[pos % N], 1'b0);
    pos++;
    if (dut_vec() !== {8'h01, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_mid got=%h exp=%h", dut_vec(), {8'h01, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0});
    end
    checks++;
  endtask

  task automatic test_stall();
    bit saw_wrap = 0;
    step('0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step('0, 1'b1);
      if (bus.wrap === 1'b1) saw_wrap = 1;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL stall k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      checks++;
    end
    if (saw_wrap || bus.err !== 1'b0 || bus.phase_idx !== 3'd0) begin
      failures++; $display("FAIL stall_hold got wrap_seen=%b err=%b idx=%0d exp 0 0 0", saw_wrap, bus.err, bus.phase_idx);
    end
    checks++;
  endtask

  task automatic test_pcnt_wrap();
    logic [7:0] last_pcnt;
    bit rolled = 0;
    step('0, 1'b0);
    pos = 0;
    last_pcnt = bus.period_cnt;
    for (int k = 0; k < 256 * N + 2; k++) begin
      drive_next();
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL pcnt_run k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      checks++;
      if (last_pcnt == 8'd255 && bus.period_cnt == 8'd0) begin
        rolled = 1;
        if (bus.wrap !== 1'b1) begin failures++; $display("FAIL pcnt_roll_wrap got=%b exp=1", bus.wrap); end
        checks++;
      end
      last_pcnt = bus.period_cnt;
    end
    if (!rolled || bus.period_cnt !== 8'd0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL pcnt_rollover got rolled=%b pcnt=%0d err=%b exp 1 0 0", rolled, bus.period_cnt, bus.err);
    end
    checks++;
  endtask

  task automatic test_random();
    int r;
    logic [W-1:0] code;
    logic rst_n;
    step('0, 1'b0);
    pos = 0;
    for (int k = 0; k < 800; k++) begin
      r     = $urandom_range(0, 99);
      rst_n = 1'b1;
      if (r < 2) begin
        rst_n = 1'b0;
        code  = code_of[pos % N];
      end else if (r < 12) begin
        code = code_of[(pos + N - 1) % N];
      end else if (r < 17) begin
        pos  += $urandom_range(1, 6);
        code = code_of[pos % N];
        pos++;
      end else if (r < 22) begin
        code = W'($urandom_range(0, 15));
      end else begin
        code = code_of[pos % N];
        pos++;
      end
      step(code, rst_n);
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    bus.jc_in = '0;
    for (int i = 0; i < 16; i++) idx_of[i] = -1;
    gen = '0;
    for (int k = 0; k < N; k++) begin
      code_of[k]  = gen;
      idx_of[gen] = k;
      gen = {gen[W-2:0], ~gen[W-1]};
    end
    m_cur = '0;
    model_update('0, 1'b0);

    test_reset();
    test_free_run();
    test_bad_code();
    test_bad_step();
    test_reset_mid();
    test_stall();
    test_pcnt_wrap();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
